// File: rtl/acorn128_dec_core.sv
// ---------------------------------------------------------------------------
// acorn128_dec_core
//
// Byte-serial ACORN-128 decryption engine. A fully initialised 293-bit state
// is loaded with a one-cycle `load` pulse. Ciphertext bytes then arrive over
// a valid/ready stream. Each byte is processed LSB first, one bit per clock.
// Every recovered plaintext bit is fed back into the state in the same way
// the encryptor fed the plaintext, so the two state machines stay identical.
// The final state is exposed on `state_out` for the tag-generation stage.
//
// Parameters
//   CA_BIT     control bit `ca` used during the message phase
//   CB_BIT     control bit `cb` used during the message phase
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   load       one-cycle pulse: capture state_in, abort any byte, go ARMED
//   state_in   initialised state S0..S292
//   ct_valid   ciphertext byte valid
//   ct_ready   core can accept a ciphertext byte (ARMED only)
//   ct_byte    ciphertext byte, processed LSB first
//   ct_last    marks the final byte of the message
//   pt_valid   recovered plaintext byte valid (OUT)
//   pt_ready   downstream accepts the plaintext byte
//   pt_byte    recovered plaintext byte
//   pt_last    ct_last captured with this byte
//   state_out  live state register
//   busy       high in RUN or OUT
//   done       high in DONE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module acorn128_dec_core #(
    parameter bit CA_BIT = 1'b1,
    parameter bit CB_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [292:0] state_in,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [7:0]   ct_byte,
    input  logic         ct_last,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [7:0]   pt_byte,
    output logic         pt_last,
    output logic [292:0] state_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_OUT,
        ST_DONE
    } fsm_e;

    fsm_e         fsm_q,     fsm_d;
    logic [292:0] state_q,   state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   ct_sh_q,   ct_sh_d;    // ciphertext, shifted right each bit
    logic [7:0]   pt_sh_q,   pt_sh_d;    // plaintext, filled from the MSB end
    logic         pt_last_q, pt_last_d;

    // -----------------------------------------------------------------------
    // One ACORN message-phase step on the live state.
    // -----------------------------------------------------------------------
    logic [292:0] s_lin;
    logic [292:0] state_step;
    logic         ks_bit;
    logic         m_bit;
    logic         f_bit;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch3(input logic a, input logic b, input logic c);
        return (a & b) ^ (~a & c);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a variable unassigned and no latch appears.
        s_lin = state_q;

        // All six LFSR feedbacks read pre-step values, hence state_q on the
        // right-hand side rather than s_lin.
        s_lin[289] = state_q[289] ^ state_q[235] ^ state_q[230];
        s_lin[230] = state_q[230] ^ state_q[196] ^ state_q[193];
        s_lin[193] = state_q[193] ^ state_q[160] ^ state_q[154];
        s_lin[154] = state_q[154] ^ state_q[111] ^ state_q[107];
        s_lin[107] = state_q[107] ^ state_q[66]  ^ state_q[61];
        s_lin[61]  = state_q[61]  ^ state_q[23]  ^ state_q[0];

        ks_bit = s_lin[12] ^ s_lin[154]
               ^ maj3(s_lin[235], s_lin[61], s_lin[193])
               ^ ch3(s_lin[230], s_lin[111], s_lin[66]);

        // Decrypt first; the recovered bit is what feeds the state.
        m_bit = ct_sh_q[0] ^ ks_bit;

        f_bit = s_lin[0] ^ ~s_lin[107]
              ^ maj3(s_lin[244], s_lin[23], s_lin[160])
              ^ (CA_BIT & s_lin[196])
              ^ (CB_BIT & ks_bit);

        state_step = {f_bit ^ m_bit, s_lin[292:1]};
    end

    // -----------------------------------------------------------------------
    // Next-state logic: load wins over everything, otherwise the FSM decides.
    // -----------------------------------------------------------------------
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ct_sh_d   = ct_sh_q;
        pt_sh_d   = pt_sh_q;
        pt_last_d = pt_last_q;

        if (load) begin
            fsm_d     = ST_ARMED;
            state_d   = state_in;
            bit_cnt_d = 3'd0;
            ct_sh_d   = 8'h00;
            pt_sh_d   = 8'h00;
            pt_last_d = 1'b0;
        end else begin
            case (fsm_q)
                ST_ARMED: begin
                    if (ct_valid) begin
                        ct_sh_d   = ct_byte;
                        pt_last_d = ct_last;
                        bit_cnt_d = 3'd0;
                        fsm_d     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d   = state_step;
                    ct_sh_d   = {1'b0, ct_sh_q[7:1]};
                    // After eight shifts the first bit sits in pt_byte[0].
                    pt_sh_d   = {m_bit, pt_sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        fsm_d = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (pt_ready) begin
                        fsm_d = pt_last_q ? ST_DONE : ST_ARMED;
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until load or rst.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            // NOTE: the 293-bit state is a flop bank, not a RAM; it is reset
            // because state_out must read zero straight after reset.
            state_q   <= '0;
            bit_cnt_q <= 3'd0;
            ct_sh_q   <= 8'h00;
            pt_sh_q   <= 8'h00;
            pt_last_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ct_sh_q   <= ct_sh_d;
            pt_sh_q   <= pt_sh_d;
            pt_last_q <= pt_last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs decode directly from registers.
    // -----------------------------------------------------------------------
    assign ct_ready  = (fsm_q == ST_ARMED);
    assign pt_valid  = (fsm_q == ST_OUT);
    assign pt_byte   = pt_sh_q;
    assign pt_last   = pt_last_q;
    assign state_out = state_q;
    assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_OUT);
    assign done      = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_acorn128_dec_core.sv
`timescale 1ns/1ps

module tb_acorn128_dec_core;

    // ---------------------------------------------------------------------
    // DUT signals: dut uses the default control bits, dut_cb has CB_BIT=1.
    // Both share every input so their handshake timing is identical.
    // ---------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [292:0] state_in;
    logic         ct_valid;
    logic [7:0]   ct_byte;
    logic         ct_last;
    logic         pt_ready;

    logic         ct_ready,  pt_valid,  pt_last,  busy,  done;
    logic [7:0]   pt_byte;
    logic [292:0] state_out;

    logic         ct_ready_cb, pt_valid_cb, pt_last_cb, busy_cb, done_cb;
    logic [7:0]   pt_byte_cb;
    logic [292:0] state_out_cb;

    acorn128_dec_core dut (
        .clk(clk), .rst(rst), .load(load), .state_in(state_in),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_byte(ct_byte),
        .ct_last(ct_last), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_byte(pt_byte), .pt_last(pt_last), .state_out(state_out),
        .busy(busy), .done(done)
    );

    acorn128_dec_core #(.CA_BIT(1'b1), .CB_BIT(1'b1)) dut_cb (
        .clk(clk), .rst(rst), .load(load), .state_in(state_in),
        .ct_valid(ct_valid), .ct_ready(ct_ready_cb), .ct_byte(ct_byte),
        .ct_last(ct_last), .pt_valid(pt_valid_cb), .pt_ready(pt_ready),
        .pt_byte(pt_byte_cb), .pt_last(pt_last_cb), .state_out(state_out_cb),
        .busy(busy_cb), .done(done_cb)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [292:0] act, input logic [292:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: an ACORN encryptor working on a plain bit vector.
    // Linear feedbacks come from a tap table; the decryptor under test must
    // reproduce the plaintext and end in the same state.
    // ---------------------------------------------------------------------
    localparam int DST[6] = '{289, 230, 193, 154, 107, 61};
    localparam int TPA[6] = '{235, 196, 160, 111, 66, 23};
    localparam int TPB[6] = '{230, 193, 154, 107, 61, 0};

    logic [292:0] ms;   // model state

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic chs(input logic a, input logic b, input logic c);
        return (a & b) ^ (~a & c);
    endfunction

    function automatic logic [292:0] linear_mix(input logic [292:0] s);
        logic [292:0] r;
        r = s;
        for (int i = 0; i < 6; i++) r[DST[i]] = s[DST[i]] ^ s[TPA[i]] ^ s[TPB[i]];
        return r;
    endfunction

    task automatic model_enc_byte(input logic [7:0] pt, input bit ca, input bit cb,
                                  output logic [7:0] ct);
        logic [292:0] s;
        logic ks, f;
        for (int k = 0; k < 8; k++) begin
            s  = linear_mix(ms);
            ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ chs(s[230], s[111], s[66]);
            ct[k] = pt[k] ^ ks;
            f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
            ms = {f ^ pt[k], s[292:1]};
        end
    endtask

    function automatic logic [292:0] rand_state();
        logic [292:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[260:0], 32'($urandom)};
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic do_load(input logic [292:0] st);
        state_in = st;
        load     = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
        check("load_ct_ready", 293'(ct_ready), 293'(1));
        check("load_state_out", state_out, st);
    endtask

    // Send one byte, wait for the plaintext, optionally stall, then accept.
    task automatic send_byte(input logic [7:0] ct, input logic last, input int stall,
                             output logic [7:0] pt0, output logic [7:0] pt1,
                             output logic pl);
        int   w   = 0;
        int   lat = 0;
        bit   stable = 1'b1;
        logic [7:0] hold;
        while (!ct_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("ct_ready_wait", 293'(ct_ready), 293'(1));
        ct_byte  = ct;
        ct_last  = last;
        ct_valid = 1'b1;
        @(posedge clk); #1;
        ct_valid = 1'b0;
        while (!pt_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 293'(lat), 293'(8));
        pt0  = pt_byte;
        pt1  = pt_byte_cb;
        pl   = pt_last;
        hold = pt_byte;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!pt_valid || pt_byte !== hold || ct_ready || !busy) stable = 1'b0;
        end
        if (stall > 0) check("backpressure_hold", 293'(stable), 293'(1));
        pt_ready = 1'b1;
        @(posedge clk); #1;
        pt_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Zero-state vectors: with S=0 the keystream stays 0, so pt = ct and the
    // top byte of the state ends as the inverted plaintext.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0] ct;
        logic [7:0] exp_pt;
        logic [7:0] exp_top;
    } zvec_t;

    zvec_t zv[4];

    initial begin
        logic [7:0]   p0, p1, pt, ct;
        logic         pl;
        logic [292:0] st_b;
        int           w;
        bit           ok;

        zv[0] = '{8'hA5, 8'hA5, 8'h5A};
        zv[1] = '{8'h00, 8'h00, 8'hFF};
        zv[2] = '{8'hFF, 8'hFF, 8'h00};
        zv[3] = '{8'h3C, 8'h3C, 8'hC3};

        rst = 1'b1; load = 1'b0; state_in = '0; ct_valid = 1'b0;
        ct_byte = 8'h00; ct_last = 1'b0; pt_ready = 1'b0;

        // ---- reset values ----
        #12;
        check("rst_ct_ready", 293'(ct_ready), 293'(0));
        check("rst_pt_valid", 293'(pt_valid), 293'(0));
        check("rst_pt_last",  293'(pt_last),  293'(0));
        check("rst_busy",     293'(busy),     293'(0));
        check("rst_done",     293'(done),     293'(0));
        check("rst_pt_byte",  293'(pt_byte),  293'(0));
        check("rst_state",    state_out,      293'(0));
        @(negedge clk);
        rst = 1'b0;

        // ---- IDLE ignores ct_valid ----
        ct_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ct_valid = 1'b0;
        check("idle_busy", 293'(busy), 293'(0));
        check("idle_ct_ready", 293'(ct_ready), 293'(0));

        // ---- zero-state table ----
        for (int i = 0; i < 4; i++) begin
            do_load('0);
            send_byte(zv[i].ct, 1'b1, 0, p0, p1, pl);
            check("zero_pt_byte", 293'(p0), 293'(zv[i].exp_pt));
            check("zero_pt_last", 293'(pl), 293'(1));
            check("zero_state_top", 293'(state_out[292:285]), 293'(zv[i].exp_top));
            check("zero_state_rest", 293'(state_out[284:0]), 293'(0));
            check("zero_done", 293'(done), 293'(1));
            check("zero_done_ct_ready", 293'(ct_ready), 293'(0));
        end

        // ---- round trip with backpressure on byte 3 ----
        ms = rand_state();
        do_load(ms);
        for (int b = 0; b < 64; b++) begin
            pt = 8'($urandom);
            model_enc_byte(pt, 1'b1, 1'b0, ct);
            send_byte(ct, (b == 63), (b == 3) ? 20 : 0, p0, p1, pl);
            check("rt_pt_byte", 293'(p0), 293'(pt));
        end
        check("rt_final_state", state_out, ms);
        check("rt_done", 293'(done), 293'(1));

        // ---- load mid-run at bit 4 ----
        ms = rand_state();
        do_load(ms);
        ct_byte = 8'($urandom); ct_last = 1'b1; ct_valid = 1'b1;
        @(posedge clk); #1;              // E0: accepted
        ct_valid = 1'b0;
        repeat (4) @(posedge clk);       // E1..E4: bits 0..3
        #1;
        st_b = rand_state();
        state_in = st_b;
        load = 1'b1;
        @(posedge clk); #1;              // E5 would have processed bit 4
        load = 1'b0;
        check("abort_ct_ready", 293'(ct_ready), 293'(1));
        check("abort_state", state_out, st_b);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (pt_valid || busy) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("abort_no_pt_valid", 293'(ok), 293'(1));
        ms = st_b;
        pt = 8'($urandom);
        model_enc_byte(pt, 1'b1, 1'b0, ct);
        send_byte(ct, 1'b1, 0, p0, p1, pl);
        check("abort_resume_pt", 293'(p0), 293'(pt));
        check("abort_resume_state", state_out, ms);

        // ---- async reset during OUT ----
        ms = rand_state();
        do_load(ms);
        ct_byte = 8'h5E; ct_last = 1'b0; ct_valid = 1'b1;
        @(posedge clk); #1;
        ct_valid = 1'b0;
        w = 0;
        while (!pt_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("arst_reach_out", 293'(pt_valid), 293'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_pt_valid", 293'(pt_valid), 293'(0));
        check("arst_busy", 293'(busy), 293'(0));
        check("arst_state", state_out, 293'(0));
        check("arst_pt_byte", 293'(pt_byte), 293'(0));
        #1;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ct_ready || busy || done) ok = 1'b0;
        end
        check("arst_idle_hold", 293'(ok), 293'(1));

        // ---- CB_BIT = 1 instance against the model with cb set ----
        ms = rand_state();
        do_load(ms);
        for (int b = 0; b < 8; b++) begin
            pt = 8'($urandom);
            model_enc_byte(pt, 1'b1, 1'b1, ct);
            send_byte(ct, (b == 7), 0, p0, p1, pl);
            check("cb_pt_byte", 293'(p1), 293'(pt));
        end
        check("cb_final_state", state_out_cb, ms);
        check("cb_done", 293'(done_cb), 293'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
